// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start, op[1:0]    : begin MULT(00)/MULTU(01)/DIV(10)/DIVU(11), sampled only in IDLE
//   a, b              : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata : direct writes to HI/LO while idle
//   busy              : operation in progress
//   done, div_by_zero : one-cycle completion pulse and divide-by-zero flag
//   hi, lo            : architectural HI/LO
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] am_q, am_d, bm_q, bm_d;
    logic        neg_q, neg_d, rneg_q, rneg_d, dbz_pend_q, dbz_pend_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d, dbz_q, dbz_d;
    logic        sgn;
    logic [31:0] a_abs, b_abs, quo, rem;
    logic [32:0] mul_sum, rem_sh, div_diff;
    logic [63:0] prod;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    always_comb begin
        sgn      = ~op[0];
        a_abs    = (sgn && a[31]) ? -a : a;
        b_abs    = (sgn && b[31]) ? -b : b;
        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? am_q : 32'd0};
        // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
        // The partial remainder is always below the divisor, so bit 32 of the difference is the borrow.
        rem_sh   = acc_q[63:31];
        div_diff = rem_sh - {1'b0, bm_q};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem      = rneg_q ? -acc_q[63:32] : acc_q[63:32];
        state_d    = state_q;
        op_d       = op_q;
        am_d       = am_q;
        bm_d       = bm_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dbz_pend_d = dbz_pend_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    am_d       = a_abs;
                    bm_d       = b_abs;
                    neg_d      = sgn & (a[31] ^ b[31]);
                    rneg_d     = sgn & a[31];
                    dbz_pend_d = op[1] & (b == 32'd0);
                    cnt_d      = 6'd0;
                    acc_d      = {32'd0, op[1] ? a_abs : b_abs};
                    state_d    = CALC;
                end else begin
                    hi_d = mthi ? wdata : hi_q;
                    lo_d = mtlo ? wdata : lo_q;
                end
            end
            CALC: begin
                if (dbz_pend_q) begin
                    dbz_pend_d = 1'b0;
                    done_d     = 1'b1;
                    dbz_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    acc_d   = !op_q[1] ? {mul_sum, acc_q[31:1]} :
                              div_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0} :
                                             {div_diff[31:0], acc_q[30:0], 1'b1};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == 6'd31) ? FIX : CALC;
                end
            end
            FIX: begin
                hi_d    = op_q[1] ? rem : prod[63:32];
                lo_d    = op_q[1] ? quo : prod[31:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            am_q       <= 32'd0;
            bm_q       <= 32'd0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            am_q       <= am_d;
            bm_q       <= bm_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dbz_pend_q <= dbz_pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;
    logic        inj = 1'b0;
    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Issues one operation, measures latency/busy, checks results and that HI/LO hold while busy.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input logic exp_dz, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, bcnt;
        logic [31:0] h0, l0;
        logic hold_bad;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        h0 = hi; l0 = lo;
        @(posedge clk);
        #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        lat = 0; hold_bad = 1'b0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (busy) bcnt++;
            if (busy && (hi !== h0 || lo !== l0)) hold_bad = 1'b1;
            if (inj && lat == 5) begin start = 1'b1; mtlo = 1'b1; mthi = 1'b1; wdata = 32'hFFFF0000; end
            if (inj && lat == 8) begin start = 1'b0; mtlo = 1'b0; mthi = 1'b0; end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (!exp_dz) chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        chk({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        chk({tag, "_hold"}, {63'd0, hold_bad}, 64'd0);
        @(posedge clk);
        #1 chk({tag, "_done_drop"}, {62'd0, done, div_by_zero}, 64'd0);
    endtask
    initial begin
        logic seen;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu", 2'b11, 32'd7, 32'd2, 33, 1'b0, 32'd1, 32'd3);
        @(negedge clk) mthi = 1'b1; wdata = 32'h12345678;
        @(negedge clk) mthi = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h12345678);
        chk("mthi_lo", {32'd0, lo}, 64'd3);
        run("divu_zero", 2'b11, 32'd99, 32'd0, 1, 1'b1, 32'h12345678, 32'd3);
        @(negedge clk) mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk) mthi = 1'b0; mtlo = 1'b0;
        chk("mv_both", {hi, lo}, 64'hA5A5A5A5_A5A5A5A5);
        mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
        run("start_mv", 2'b11, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
        inj = 1'b1;
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h00000000, 32'h80000000);
        inj = 1'b0;
        run("mult_mixed", 2'b00, 32'h00001000, 32'h80000000, 33, 1'b0, 32'hFFFFF800, 32'h00000000);
        @(negedge clk) op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        chk("mid_rst_no_done", {63'd0, seen}, 64'd0);
        run("mult_after_rst", 2'b00, 32'd5, 32'd6, 33, 1'b0, 32'd0, 32'd30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
